gate_scan_ctrl: RTL and testbench

- Sequencer that exhaustively exercises a multi-input gate core (the norgate-style block: up to 8 inputs a..h, WIDTH lanes each, output q).
- On start, walks every input combination of the first PORT_NUM inputs, waits for the gate to settle, captures q, and builds the gate's truth table.
- Sits between the lab top-level (buttons/switches/LEDs) and the gate under test; used for self-check of the gate IP on the board.

---
 rtl/gate_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_gate_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_scan_ctrl.sv
// gate_scan_ctrl: walks every input combination of the first PORT_NUM inputs
// of a multi-input gate, waits SETTLE_CYCLES, captures lane-0 of q into a
// truth table and flags lanes that disagree.
// Optional feature macro: GATE_SCAN_CHECK_EN (compare table against NOR).
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   start          scan request, sampled only when idle
//   busy           high while driving/settling/capturing
//   done           one-cycle pulse once the table is complete
//   gate_in        packed gate inputs, input k at [k*WIDTH +: WIDTH]
//   gate_q         gate output under test
//   result         truth table, result[i] = lane-0 q for combination i
//   lane_err       sticky lane disagreement flag
//   pass           table equals NOR table with no lane error (feature only)
module gate_scan_ctrl #(
   parameter int unsigned PORT_NUM      = 2,
   parameter int unsigned WIDTH         = 1,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [8*WIDTH-1:0]         gate_in,
   input  logic [WIDTH-1:0]           gate_q,
   output logic [(1<<PORT_NUM)-1:0]   result,
   output logic                       lane_err,
   output logic                       pass
);

   localparam int unsigned N_COMB = 1 << PORT_NUM;
   localparam int unsigned CNT_W  = 4;
   localparam logic [PORT_NUM-1:0] IDX_LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t               state, state_d;
   logic [PORT_NUM-1:0]  index, index_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [8*WIDTH-1:0]   gate_in_d;
   logic [N_COMB-1:0]    result_d;
   logic                 lane_err_d;
   logic                 busy_d;
   logic                 done_d;
   logic [8*WIDTH-1:0]   drive_pat;

   // Input pattern for the current index: bit k replicated across all lanes.
   for (genvar k = 0; k < 8; k++) begin : g_pat
      if (k < PORT_NUM) begin : g_used
         assign drive_pat[k*WIDTH +: WIDTH] = {WIDTH{index[k]}};
      end else begin : g_unused
         assign drive_pat[k*WIDTH +: WIDTH] = '0;
      end
   end

`ifdef GATE_SCAN_CHECK_EN
   localparam logic [N_COMB-1:0] NOR_TABLE = N_COMB'(1);
   logic pass_q, pass_d;
   assign pass = pass_q;
`else
   assign pass = 1'b0;
`endif

   // Next-state and next-output computation.
   always_comb begin
      state_d    = state;
      index_d    = index;
      cnt_d      = cnt;
      gate_in_d  = gate_in;
      result_d   = result;
      lane_err_d = lane_err;
      done_d     = 1'b0;
`ifdef GATE_SCAN_CHECK_EN
      pass_d     = pass_q;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               state_d    = S_DRIVE;
               index_d    = '0;
               result_d   = '0;
               lane_err_d = 1'b0;
`ifdef GATE_SCAN_CHECK_EN
               pass_d     = 1'b0;
`endif
            end
         end
         S_DRIVE: begin
            gate_in_d = drive_pat;
            cnt_d     = CNT_W'(SETTLE_CYCLES);
            state_d   = S_SETTLE;
         end
         S_SETTLE: begin
            cnt_d = cnt - 4'd1;
            if (cnt <= 4'd1) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            result_d[index] = gate_q[0];
            if (gate_q != {WIDTH{gate_q[0]}}) lane_err_d = 1'b1;
            if (index == IDX_LAST) begin
               state_d = S_DONE;
            end else begin
               index_d = index + 1'b1;
               state_d = S_DRIVE;
            end
         end
         S_DONE: begin
            done_d    = 1'b1;
            gate_in_d = '0;
`ifdef GATE_SCAN_CHECK_EN
            pass_d    = (result == NOR_TABLE) && !lane_err;
`endif
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_CAPTURE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         index    <= '0;
         cnt      <= '0;
         gate_in  <= '0;
         result   <= '0;
         lane_err <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef GATE_SCAN_CHECK_EN
         pass_q   <= 1'b0;
`endif
      end else begin
         state    <= state_d;
         index    <= index_d;
         cnt      <= cnt_d;
         gate_in  <= gate_in_d;
         result   <= result_d;
         lane_err <= lane_err_d;
         busy     <= busy_d;
         done     <= done_d;
`ifdef GATE_SCAN_CHECK_EN
         pass_q   <= pass_d;
`endif
      end
   end

endmodule

// File: tb/tb_gate_scan_ctrl.sv
// Directed bench for gate_scan_ctrl: three instances (2 inputs x 1 lane,
// 2 inputs x 2 lanes, 8 inputs x 1 lane with SETTLE_CYCLES=3) each driving a
// behavioural NOR model with selectable faults.
module tb_gate_scan_ctrl;

`ifdef GATE_SCAN_CHECK_EN
   localparam logic PASS_EN = 1'b1;
`else
   localparam logic PASS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int   sel = 0;
   logic start_r = 1'b0;
   logic stuck_a = 1'b0;
   logic inv_b = 1'b0;
   int   n_chk = 0;
   int   n_bad = 0;

   logic start_a, start_b, start_c;
   assign start_a = start_r && (sel == 0);
   assign start_b = start_r && (sel == 1);
   assign start_c = start_r && (sel == 2);

   logic         busy_a, done_a, lerr_a, pass_a;
   logic [7:0]   gin_a;
   logic [0:0]   q_a;
   logic [3:0]   res_a;
   logic         busy_b, done_b, lerr_b, pass_b;
   logic [15:0]  gin_b;
   logic [1:0]   q_b;
   logic [3:0]   res_b;
   logic         busy_c, done_c, lerr_c, pass_c;
   logic [7:0]   gin_c;
   logic [0:0]   q_c;
   logic [255:0] res_c;
   logic         nor_b;

   // Gate models: NOR over all inputs per lane, plus fault injection.
   assign q_a   = stuck_a ? 1'b1 : ~|gin_a;
   assign nor_b = ~|(gin_b & 16'h5555);
   assign q_b   = {nor_b ^ inv_b, nor_b};
   assign q_c   = ~|gin_c;

   gate_scan_ctrl #(.PORT_NUM(2), .WIDTH(1), .SETTLE_CYCLES(1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
      .gate_in(gin_a), .gate_q(q_a), .result(res_a), .lane_err(lerr_a), .pass(pass_a));
   gate_scan_ctrl #(.PORT_NUM(2), .WIDTH(2), .SETTLE_CYCLES(1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
      .gate_in(gin_b), .gate_q(q_b), .result(res_b), .lane_err(lerr_b), .pass(pass_b));
   gate_scan_ctrl #(.PORT_NUM(8), .WIDTH(1), .SETTLE_CYCLES(3)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
      .gate_in(gin_c), .gate_q(q_c), .result(res_c), .lane_err(lerr_c), .pass(pass_c));

   logic         busy_s, done_s, lerr_s, pass_s;
   logic [255:0] gin_s, res_s;

   // Selected-instance view.
   always_comb begin
      busy_s = busy_a; done_s = done_a; lerr_s = lerr_a; pass_s = pass_a;
      gin_s  = 256'(gin_a); res_s = 256'(res_a);
      if (sel == 1) begin
         busy_s = busy_b; done_s = done_b; lerr_s = lerr_b; pass_s = pass_b;
         gin_s  = 256'(gin_b); res_s = 256'(res_b);
      end else if (sel == 2) begin
         busy_s = busy_c; done_s = done_c; lerr_s = lerr_c; pass_s = pass_c;
         gin_s  = 256'(gin_c); res_s = 256'(res_c);
      end
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] exp_pat(input int pn, input int w, input int i);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < pn; k++)
         for (int l = 0; l < w; l++)
            r[k*w+l] = i[k];
      return r;
   endfunction

   // Start a scan on instance s and wait (bounded) for done. Optionally
   // re-pulse start at cycle poke, or pull reset at cycle abort.
   task automatic run(input int s, input bit hold, input int poke, input int abort,
                      output int cyc);
      int per, ncomb, pn, w;
      bit fin;
      sel = s;
      per = (s == 2) ? 5 : 3;
      ncomb = (s == 2) ? 256 : 4;
      pn = (s == 2) ? 8 : 2;
      w = (s == 1) ? 2 : 1;
      @(posedge clk); #1 start_r = 1'b1;
      @(posedge clk); #1;
      if (!hold) start_r = 1'b0;
      chk("busy_go", 256'(busy_s), 256'(1));
      cyc = 0;
      fin = 1'b0;
      while (!fin && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         if (poke != 0 && cyc == poke) start_r = 1'b1;
         if (poke != 0 && cyc == poke + 1) start_r = 1'b0;
         if (cyc % per == 1 && cyc / per < ncomb)
            chk("pattern", gin_s, exp_pat(pn, w, cyc / per));
         if (abort != 0 && cyc == abort) begin
            rst_n = 1'b0;
            #2;
            chk("rst_busy", 256'(busy_s), 256'(0));
            chk("rst_done", 256'(done_s), 256'(0));
            chk("rst_gin", gin_s, 256'(0));
            chk("rst_res", res_s, 256'(0));
            chk("rst_lerr", 256'(lerr_s), 256'(0));
            chk("rst_pass", 256'(pass_s), 256'(0));
            @(negedge clk) rst_n = 1'b1;
            fin = 1'b1;
         end else if (done_s) begin
            fin = 1'b1;
         end
      end
   endtask

   task automatic check_end(input logic [255:0] eres, input logic elerr, input logic epass);
      chk("result", res_s, eres);
      chk("lane_err", 256'(lerr_s), 256'(elerr));
      chk("pass", 256'(pass_s), 256'(epass));
      chk("gin_idle", gin_s, 256'(0));
      chk("busy_end", 256'(busy_s), 256'(0));
      @(posedge clk); #1;
      chk("done_pulse", 256'(done_s), 256'(0));
      chk("busy_idle", 256'(busy_s), 256'(0));
   endtask

   initial begin
      int cyc;
      #1 rst_n = 1'b0;
      #2;
      chk("r_busy", 256'(busy_a), 256'(0));
      chk("r_done", 256'(done_a), 256'(0));
      chk("r_gin", 256'(gin_a), 256'(0));
      chk("r_res", 256'(res_a), 256'(0));
      chk("r_lerr", 256'(lerr_a), 256'(0));
      chk("r_pass", 256'(pass_a), 256'(0));
      chk("r_res_c", res_c, 256'(0));
      @(negedge clk) rst_n = 1'b1;

      // Real NOR, 2 inputs
      run(0, 1'b0, 0, 0, cyc);
      chk("a_lat", 256'(cyc), 256'(13));
      check_end(256'h1, 1'b0, PASS_EN);

      // q stuck-at-1
      stuck_a = 1'b1;
      run(0, 1'b0, 0, 0, cyc);
      chk("stuck_lat", 256'(cyc), 256'(13));
      check_end(256'hf, 1'b0, 1'b0);
      stuck_a = 1'b0;

      // Two lanes, lane 1 inverted
      inv_b = 1'b1;
      run(1, 1'b0, 0, 0, cyc);
      chk("b_lat", 256'(cyc), 256'(13));
      check_end(256'h1, 1'b1, 1'b0);
      inv_b = 1'b0;

      // start re-pulsed during settle of combination 1
      run(0, 1'b0, 4, 0, cyc);
      chk("poke_lat", 256'(cyc), 256'(13));
      check_end(256'h1, 1'b0, PASS_EN);

      // Reset during combination 2, then a clean scan
      run(0, 1'b0, 0, 7, cyc);
      run(0, 1'b0, 0, 0, cyc);
      chk("post_rst_lat", 256'(cyc), 256'(13));
      check_end(256'h1, 1'b0, PASS_EN);

      // start held high re-triggers right after done
      run(0, 1'b1, 0, 0, cyc);
      chk("hold_lat", 256'(cyc), 256'(13));
      chk("hold_res", res_s, 256'h1);
      @(posedge clk); #1;
      chk("retrig_busy", 256'(busy_s), 256'(1));
      chk("retrig_res", res_s, 256'(0));
      chk("retrig_done", 256'(done_s), 256'(0));
      start_r = 1'b0;
      cyc = 0;
      while (!done_s && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("retrig_lat", 256'(cyc), 256'(13));
      check_end(256'h1, 1'b0, PASS_EN);

      // 8 inputs, SETTLE_CYCLES=3
      run(2, 1'b0, 0, 0, cyc);
      chk("c_lat", 256'(cyc), 256'(1281));
      check_end(256'h1, 1'b0, PASS_EN);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
